interrupt_controller: RTL

Memory-mapped machine-level interrupt controller that sits directly downstream of the `timer` block. It consumes `timer_interrupt`, a software-interrupt register, and `NUM_SOURCES` external lines, and presents registered interrupt requests to the core. It shares the timer's bus protocol, so one address decoder serves both. External sources go through a claim/complete handshake with fixed lowest-ID-wins priority.

---
 rtl/intc_pkg.sv | 13 +
 rtl/intc_gateway.sv | 68 ++++++
 rtl/interrupt_controller.sv | 119 +++++++++++
 3 files changed

// File: rtl/intc_pkg.sv
// Shared types and constants for the machine-level interrupt controller.
package intc_pkg;

    typedef enum logic [1:0] {
        GW_IDLE,
        GW_PENDING,
        GW_IN_SERVICE
    } gw_state_e;

    localparam int ID_W = 5;
    localparam logic [ID_W-1:0] NO_IRQ_ID = '0;

endpackage

// File: rtl/intc_gateway.sv
// Per-source claim/complete gateway. Defining INTC_EDGE_DETECT_EN makes it
// trigger on request rising edges instead of levels.
module intc_gateway
    import intc_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic claim_hit_i,
    input  logic complete_hit_i,
    output logic pending_o
);

    gw_state_e state_q;
    logic      pending_q;
    logic      trig;

`ifdef INTC_EDGE_DETECT_EN
    logic req_d_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_d_q <= 1'b0;
        end else begin
            req_d_q <= req_i;
        end
    end

    // Edges seen outside IDLE are dropped, as the FSM only looks at trig in IDLE
    assign trig = req_i & ~req_d_q;
`else
    assign trig = req_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= GW_IDLE;
            pending_q <= 1'b0;
        end else begin
            case (state_q)
                GW_IDLE: begin
                    if (trig) begin
                        state_q   <= GW_PENDING;
                        pending_q <= 1'b1;
                    end
                end
                GW_PENDING: begin
                    if (claim_hit_i) begin
                        state_q   <= GW_IN_SERVICE;
                        pending_q <= 1'b0;
                    end
                end
                GW_IN_SERVICE: begin
                    if (complete_hit_i) begin
                        state_q <= GW_IDLE;
                    end
                end
                default: begin
                    state_q   <= GW_IDLE;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped machine interrupt controller: MSIP, timer pass-through and
// prioritised external sources. Optional macro: INTC_EDGE_DETECT_EN.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32,
    parameter int NUM_SOURCES  = 8,
    parameter logic [ADDRESS_BITS-1:0] MSIP_ADDR    = 'h0020_0000,
    parameter logic [ADDRESS_BITS-1:0] PENDING_ADDR = 'h0C00_1000,
    parameter logic [ADDRESS_BITS-1:0] ENABLE_ADDR  = 'h0C00_2000,
    parameter logic [ADDRESS_BITS-1:0] CLAIM_ADDR   = 'h0C20_0004
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      readEnable,
    input  logic                      writeEnable,
    input  logic [DATA_WIDTH/8-1:0]   writeByteEnable,
    input  logic [ADDRESS_BITS-1:0]   address,
    input  logic [DATA_WIDTH-1:0]     writeData,
    output logic [DATA_WIDTH-1:0]     readData,
    input  logic                      timer_interrupt,
    input  logic [NUM_SOURCES-1:0]    irq_sources,
    output logic                      software_interrupt,
    output logic                      timer_interrupt_out,
    output logic                      external_interrupt
);

    logic [NUM_SOURCES:1]  pending;
    logic [NUM_SOURCES:1]  pend_en;
    logic [NUM_SOURCES:1]  enable_q, enable_d;
    logic [NUM_SOURCES:1]  claim_hit, complete_hit;
    logic [ID_W-1:0]       claim_id;
    logic [DATA_WIDTH-1:0] readData_q, readData_d;
    logic                  msip_q, msip_d;
    logic                  timer_q;
    logic                  ext_q;
    logic                  rd, wr;
    logic                  hit_msip, hit_pending, hit_enable, hit_claim;
    logic                  unused_bus;

    // A simultaneous write suppresses the read and any claim side effect
    assign rd          = readEnable & ~writeEnable;
    assign wr          = writeEnable;
    assign hit_msip    = (address == MSIP_ADDR);
    assign hit_pending = (address == PENDING_ADDR);
    assign hit_enable  = (address == ENABLE_ADDR);
    assign hit_claim   = (address == CLAIM_ADDR);
    assign pend_en     = pending & enable_q;
    assign unused_bus  = ^{writeData, writeByteEnable};

    for (genvar g = 1; g <= NUM_SOURCES; g++) begin : g_gw
        intc_gateway u_gw (
            .clk_i          (clock),
            .rst_i          (reset),
            .req_i          (irq_sources[g-1]),
            .claim_hit_i    (claim_hit[g]),
            .complete_hit_i (complete_hit[g]),
            .pending_o      (pending[g])
        );
    end

    // Lowest ID wins: scan downward so the last match is the smallest ID
    always_comb begin
        claim_id = NO_IRQ_ID;
        for (int i = NUM_SOURCES; i >= 1; i--) begin
            if (pend_en[i]) claim_id = ID_W'(i);
        end
    end

    always_comb begin
        claim_hit    = '0;
        complete_hit = '0;
        enable_d     = enable_q;
        for (int i = 1; i <= NUM_SOURCES; i++) begin
            claim_hit[i]    = rd && hit_claim && (claim_id == ID_W'(i));
            complete_hit[i] = wr && hit_claim && writeByteEnable[0] &&
                              (writeData[ID_W-1:0] == ID_W'(i));
            if (wr && hit_enable && writeByteEnable[i/8]) enable_d[i] = writeData[i];
        end
    end

    always_comb begin
        msip_d = msip_q;
        if (wr && hit_msip && writeByteEnable[0]) msip_d = writeData[0];
    end

    always_comb begin
        readData_d = '0;
        if (rd) begin
            if (hit_pending)     readData_d[NUM_SOURCES:1] = pending;
            else if (hit_enable) readData_d[NUM_SOURCES:1] = enable_q;
            else if (hit_claim)  readData_d[ID_W-1:0]      = claim_id;
            else if (hit_msip)   readData_d[0]             = msip_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            enable_q   <= '0;
            msip_q     <= 1'b0;
            readData_q <= '0;
            timer_q    <= 1'b0;
            ext_q      <= 1'b0;
        end else begin
            enable_q   <= enable_d;
            msip_q     <= msip_d;
            readData_q <= readData_d;
            timer_q    <= timer_interrupt;
            ext_q      <= |pend_en;
        end
    end

    assign readData            = readData_q;
    assign software_interrupt  = msip_q;
    assign timer_interrupt_out = timer_q;
    assign external_interrupt  = ext_q;

endmodule
